ipd_sequencer: RTL

- Sample-driven sequencer for the servo I-PD controller.
- On each ADC data strobe it captures the measurement and reference, then forms the error and the first and second differences.
- It time-shares one external signed multiplier across the Ki, Kp and Kd terms, accumulates the incremental control law, then saturates it and publishes a new PWM duty word.
- It sits between the ADC interface and the PWM generator inside Top.

---
 rtl/ipd_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ipd_sequencer.sv
// ipd_sequencer: per-sample I-PD control law using one shared external multiplier.
// Forms error and differences, accumulates ki*e - kp*dy - kd*d2y onto u_prev, clamps to duty.
module ipd_sequencer #(
  parameter int DW        = 12,
  parameter int FRAC      = 8,
  parameter int DUTY_INIT = 0
) (
  input  logic          clk_i,
  input  logic          reset,
  input  logic          dataf_i,
  input  logic [DW-1:0] ADC_i,
  input  logic [DW-1:0] ref_i,
  input  logic [DW-1:0] ki_i,
  input  logic [DW-1:0] kp_i,
  input  logic [DW-1:0] kd_i,
  output logic          mul_start_o,
  output logic [15:0]   mul_a_o,
  output logic [15:0]   mul_b_o,
  input  logic          mul_done_i,
  input  logic [31:0]   mul_p_i,
  output logic [DW-1:0] duty_o,
  output logic          duty_valid_o,
  output logic          busy_o,
  output logic          overrun_o
);
  typedef enum logic [2:0] {IDLE, DIFF, MUL_I, MUL_P, MUL_D, SAT} state_t;
  localparam logic signed [33:0] UMAX = 34'((64'd1 << DW) - 64'd1);
  state_t state_q, state_d;
  logic dataf_q, primed_q, primed_d, started_q, started_d;
  logic duty_valid_q, duty_valid_d, overrun_q, overrun_d;
  logic [DW-1:0] y_q, y_d, r_q, r_d, y1_q, y1_d, y2_q, y2_d;
  logic [DW-1:0] u_prev_q, u_prev_d, duty_q, duty_d, y1_eff, y2_eff, u_sat;
  logic [DW:0] e_q, e_d, dy_q, dy_d;
  logic [DW+1:0] d2y_q, d2y_d;
  logic signed [33:0] acc_q, acc_d, p_ext, acc_base, u_shift;
  logic trig, mul_st;
  assign trig     = dataf_i & ~dataf_q;
  assign mul_st   = state_q inside {MUL_I, MUL_P, MUL_D};
  assign y1_eff   = primed_q ? y1_q : y_q;
  assign y2_eff   = primed_q ? y2_q : y_q;
  assign p_ext    = {{2{mul_p_i[31]}}, mul_p_i};
  assign acc_base = {{(34-DW-FRAC){1'b0}}, u_prev_q, {FRAC{1'b0}}};
  assign u_shift  = acc_q >>> FRAC;
  // Clamping the stored u_prev as well as duty is what provides anti-windup.
  assign u_sat    = u_shift[33] ? '0 : (u_shift > UMAX) ? {DW{1'b1}} : u_shift[DW-1:0];
  assign mul_start_o  = mul_st & ~started_q;
  assign duty_o       = duty_q;
  assign duty_valid_o = duty_valid_q;
  assign busy_o       = state_q != IDLE;
  assign overrun_o    = overrun_q;
  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    r_d          = r_q;
    y1_d         = y1_q;
    y2_d         = y2_q;
    e_d          = e_q;
    dy_d         = dy_q;
    d2y_d        = d2y_q;
    acc_d        = acc_q;
    u_prev_d     = u_prev_q;
    primed_d     = primed_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    overrun_d    = overrun_q | (trig & (state_q != IDLE));
    started_d    = mul_st & ~mul_done_i;
    mul_a_o      = '0;
    mul_b_o      = '0;
    case (state_q)
      IDLE: if (trig) begin
        y_d     = ADC_i;
        r_d     = ref_i;
        state_d = DIFF;
      end
      DIFF: begin
        e_d      = {1'b0, r_q} - {1'b0, y_q};
        dy_d     = {1'b0, y_q} - {1'b0, y1_eff};
        d2y_d    = {2'b0, y_q} - {1'b0, y1_eff, 1'b0} + {2'b0, y2_eff};
        y1_d     = y1_eff;
        y2_d     = y2_eff;
        primed_d = 1'b1;
        state_d  = MUL_I;
      end
      MUL_I: begin
        mul_a_o = {{(16-DW){1'b0}}, ki_i};
        mul_b_o = {{(15-DW){e_q[DW]}}, e_q};
        if (mul_done_i) begin
          acc_d   = acc_base + p_ext;
          state_d = MUL_P;
        end
      end
      MUL_P: begin
        mul_a_o = {{(16-DW){1'b0}}, kp_i};
        mul_b_o = {{(15-DW){dy_q[DW]}}, dy_q};
        if (mul_done_i) begin
          acc_d   = acc_q - p_ext;
          state_d = MUL_D;
        end
      end
      MUL_D: begin
        mul_a_o = {{(16-DW){1'b0}}, kd_i};
        mul_b_o = {{(14-DW){d2y_q[DW+1]}}, d2y_q};
        if (mul_done_i) begin
          acc_d   = acc_q - p_ext;
          state_d = SAT;
        end
      end
      SAT: begin
        duty_d       = u_sat;
        u_prev_d     = u_sat;
        y2_d         = y1_q;
        y1_d         = y_q;
        duty_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      dataf_q      <= 1'b0;
      y_q          <= '0;
      r_q          <= '0;
      y1_q         <= '0;
      y2_q         <= '0;
      e_q          <= '0;
      dy_q         <= '0;
      d2y_q        <= '0;
      acc_q        <= '0;
      u_prev_q     <= '0;
      primed_q     <= 1'b0;
      started_q    <= 1'b0;
      duty_q       <= DW'(DUTY_INIT);
      duty_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dataf_q      <= dataf_i;
      y_q          <= y_d;
      r_q          <= r_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      e_q          <= e_d;
      dy_q         <= dy_d;
      d2y_q        <= d2y_d;
      acc_q        <= acc_d;
      u_prev_q     <= u_prev_d;
      primed_q     <= primed_d;
      started_q    <= started_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule
